message_compose_buffer: RTL and testbench
=========================================

Name: message_compose_buffer

Overview:
Consumes decoded characters from the PS/2 keyboard wrapper (its data_ready, output_ascii and reset handshake) and assembles them into an outgoing message line. Supports backspace and emoji codes, and exposes a random-read port for the on-screen compose line. On Enter, streams the stored line plus an 8'h0A terminator to the downstream transmitter over a valid/ready handshake. Sits between ps2_interface_wrapper and the message transmit/serializer stage.

Parameters:
MAX_LEN, 32, maximum stored characters per message (power of two, ≥4).
ADDR_W, 5, log2(MAX_LEN); width of rd_addr.

Ports:
fpga_clock  in  1  system clock, all logic on rising edge.
reset  in  1  synchronous, active-high.
char_valid  in  1  level from the wrapper's data_ready; a character is pending.
char_ascii  in  8  character code from the wrapper's output_ascii.
char_ack  out  1  one-cycle pulse; drives the wrapper's reset input to consume the character.
tx_data  out  8  byte to the transmitter.
tx_valid  out  1  tx_data is valid.
tx_ready  in  1  transmitter accepts the byte when tx_valid && tx_ready at a clock edge.
rd_addr  in  ADDR_W  display read index.
rd_data  out  8  buffer[rd_addr], combinational; 8'h00 when rd_addr ≥ length.
length  out  ADDR_W+1  number of stored characters, 0..MAX_LEN.
buffer_full  out  1  length == MAX_LEN.
sending  out  1  high while in SEND or TERM.

Behaviour:
- Reset, from any state including mid-send: state=COLLECT, length=0, char_ack=0, tx_valid=0, tx_data=0, send index=0. Buffer contents need not be cleared.
- States: COLLECT, ACK, WAIT_LOW, SEND, TERM.
- COLLECT: when char_valid=1, classify char_ascii in the same cycle, update the buffer and length at that edge, then go to ACK. When char_valid=0, stay.
- Classification:
  - 8'h20–8'h7E and 8'd128–8'd131 (emoji): printable. If length<MAX_LEN, write to buffer[length] and increment length. If the buffer is full, drop the character silently.
  - 8'h08 (backspace): if length>0, decrement length; at length 0, no-op.
  - 8'h0A (Enter): if length>0, set next-after-ack target to SEND; if length 0, ignore.
  - Any other code: ignored, but still acked.
- ACK: char_ack=1 for exactly this one cycle, then go to WAIT_LOW. Every char_valid seen in COLLECT is acked exactly once.
- WAIT_LOW: remain until char_valid=0. This guards against the wrapper's registered data_ready still being high for 1–2 cycles after ack. Then go to SEND if Enter was latched, else COLLECT.
- SEND:
  - tx_valid=1, tx_data=buffer[idx], with idx starting at 0.
  - On tx_valid&&tx_ready: idx++. After idx==length-1 is accepted, go to TERM.
  - tx_data must hold stable while tx_valid=1 and tx_ready=0.
- TERM: tx_valid=1, tx_data=8'h0A. On acceptance: tx_valid=0, length=0, idx=0, go to COLLECT.
- Throughput: one byte per cycle when tx_ready is held high. A message of N chars takes N+1 accepted beats.
- During SEND and TERM, char_valid is not acked and the buffer is frozen. Keystrokes stay pending in the wrapper and are processed after return to COLLECT.
- A character arriving together with reset is discarded.
- length and buffer_full update on the edge where a write or backspace commits. rd_data reflects that update in the following cycle.

Decomposition:
- Shared package: state encoding; constants ASCII_BS=8'h08, ASCII_LF=8'h0A, ASCII_PRINT_LO=8'h20, ASCII_PRINT_HI=8'h7E, EMOJI_LO=8'd128, EMOJI_HI=8'd131.
- Sub-module compose_char_ram: MAX_LEN×8 storage with one write port and two read ports (display + send). Keeps it inferable as distributed RAM.

Test Plan:
- Type 'H','I' (8'h48, 8'h49) as char_valid levels of 5 cycles each, then press Enter with tx_ready=1 → tx_data sequence 48,49,0A on consecutive valid beats. Then length=0, and char_ack pulses exactly 3 times, each 1 cycle wide.
- Type 'A','B', then 8'h08, then 'C' → length=2, rd_addr 0/1 gives 41/43, rd_addr 2 gives 00.
- Press 8'h08 and Enter at length 0 → each is acked, length stays 0, tx_valid never rises.
- Type 33 printable chars with MAX_LEN=32 → buffer_full=1, length=32, 33rd char acked but dropped, buffer[31] = 32nd char.
- Send 3 chars with tx_ready toggling 1,0,0,1,0,1,1 → tx_data stays stable while stalled, exactly 4 accepted beats (3 chars + 0A), and a keystroke held during send is acked only after TERM completes.
- Emoji 8'd130 then Enter → beats 82,0A. Assert reset mid-SEND after beat 1 → next cycle tx_valid=0, length=0, state COLLECT.

Source files
------------

// File: rtl/message_compose_buffer_pkg.sv
// Shared types and character constants for the message compose buffer.
// Holds the FSM state encoding and the keystroke classifier.
package message_compose_buffer_pkg;

    typedef enum logic [2:0] {
        ST_COLLECT  = 3'd0,
        ST_ACK      = 3'd1,
        ST_WAIT_LOW = 3'd2,
        ST_SEND     = 3'd3,
        ST_TERM     = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        CH_PRINT = 2'd0,
        CH_BS    = 2'd1,
        CH_LF    = 2'd2,
        CH_OTHER = 2'd3
    } char_class_e;

    localparam logic [7:0] ASCII_BS       = 8'h08;
    localparam logic [7:0] ASCII_LF       = 8'h0A;
    localparam logic [7:0] ASCII_PRINT_LO = 8'h20;
    localparam logic [7:0] ASCII_PRINT_HI = 8'h7E;
    localparam logic [7:0] EMOJI_LO       = 8'd128;
    localparam logic [7:0] EMOJI_HI       = 8'd131;

    function automatic char_class_e classify_char(input logic [7:0] c);
        char_class_e cls;
        if ((c >= ASCII_PRINT_LO && c <= ASCII_PRINT_HI) ||
            (c >= EMOJI_LO && c <= EMOJI_HI)) begin
            cls = CH_PRINT;
        end else if (c == ASCII_BS) begin
            cls = CH_BS;
        end else if (c == ASCII_LF) begin
            cls = CH_LF;
        end else begin
            cls = CH_OTHER;
        end
        return cls;
    endfunction

endpackage

// File: rtl/compose_char_ram.sv
// Character store for the compose line: one write port, two asynchronous
// read ports (display and send), kept simple so it maps to distributed RAM.
module compose_char_ram #(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [7:0]        disp_data,
    input  logic [ADDR_W-1:0] send_addr,
    output logic [7:0]        send_data
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign disp_data = mem[disp_addr];
    assign send_data = mem[send_addr];

endmodule

// File: rtl/message_compose_buffer.sv
// Assembles keystrokes from the PS/2 wrapper into a message line and, on
// Enter, streams the line plus a line-feed terminator to the transmitter.
module message_compose_buffer
    import message_compose_buffer_pkg::*;
#(
    parameter int unsigned MAX_LEN = 32,
    parameter int unsigned ADDR_W  = 5
) (
    input  logic              fpga_clock,
    input  logic              reset,
    input  logic              char_valid,
    input  logic [7:0]        char_ascii,
    output logic              char_ack,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic [ADDR_W:0]   length,
    output logic              buffer_full,
    output logic              sending
);

    localparam int unsigned   LEN_W   = ADDR_W + 1;
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              enter_q, enter_d;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [7:0]        disp_data;
    logic [7:0]        send_data;

    compose_char_ram #(
        .DEPTH  (MAX_LEN),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk       (fpga_clock),
        .we        (ram_we),
        .waddr     (ram_waddr),
        .wdata     (char_ascii),
        .disp_addr (rd_addr),
        .disp_data (disp_data),
        .send_addr (idx_q),
        .send_data (send_data)
    );

    always_ff @(posedge fpga_clock) begin
        if (reset) begin
            state_q <= ST_COLLECT;
            len_q   <= '0;
            idx_q   <= '0;
            enter_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            enter_q <= enter_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        enter_d   = enter_q;
        ram_we    = 1'b0;
        ram_waddr = len_q[ADDR_W-1:0];

        case (state_q)
            ST_COLLECT: begin
                if (char_valid) begin
                    case (classify_char(char_ascii))
                        CH_PRINT: begin
                            if (len_q != LEN_MAX) begin
                                ram_we = 1'b1;
                                len_d  = len_q + LEN_ONE;
                            end
                        end
                        CH_BS: begin
                            if (len_q != '0) begin
                                len_d = len_q - LEN_ONE;
                            end
                        end
                        CH_LF: begin
                            if (len_q != '0) begin
                                enter_d = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                state_d = ST_WAIT_LOW;
            end
            // The wrapper's data_ready can linger after the ack; wait it out
            // so one keystroke is never consumed twice.
            ST_WAIT_LOW: begin
                if (!char_valid) begin
                    if (enter_q) begin
                        enter_d = 1'b0;
                        idx_d   = '0;
                        state_d = ST_SEND;
                    end else begin
                        state_d = ST_COLLECT;
                    end
                end
            end
            ST_SEND: begin
                if (tx_ready) begin
                    if ({1'b0, idx_q} == len_q - LEN_ONE) begin
                        idx_d   = '0;
                        state_d = ST_TERM;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_TERM: begin
                if (tx_ready) begin
                    len_d   = '0;
                    idx_d   = '0;
                    state_d = ST_COLLECT;
                end
            end
            default: begin
                state_d = ST_COLLECT;
            end
        endcase
    end

    // The buffer is frozen while sending, so send_data is stable under stall.
    always_comb begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        if (state_q == ST_SEND) begin
            tx_valid = 1'b1;
            tx_data  = send_data;
        end else if (state_q == ST_TERM) begin
            tx_valid = 1'b1;
            tx_data  = ASCII_LF;
        end
    end

    assign char_ack    = (state_q == ST_ACK);
    assign sending     = tx_valid;
    assign length      = len_q;
    assign buffer_full = (len_q == LEN_MAX);
    assign rd_data     = ({1'b0, rd_addr} < len_q) ? disp_data : 8'h00;

endmodule

// File: tb/tb_message_compose_buffer.sv
// Randomized and directed bench for message_compose_buffer against a
// queue-based model of the compose line and outgoing byte stream.
module tb_message_compose_buffer;

    localparam int MAX_LEN = 32;
    localparam int ADDR_W  = 5;

    logic              fpga_clock = 1'b0;
    logic              reset      = 1'b1;
    logic              char_valid = 1'b0;
    logic [7:0]        char_ascii = 8'h00;
    logic              char_ack;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready   = 1'b0;
    logic [ADDR_W-1:0] rd_addr    = '0;
    logic [7:0]        rd_data;
    logic [ADDR_W:0]   length;
    logic              buffer_full;
    logic              sending;

    message_compose_buffer #(
        .MAX_LEN (MAX_LEN),
        .ADDR_W  (ADDR_W)
    ) dut (
        .fpga_clock  (fpga_clock),
        .reset       (reset),
        .char_valid  (char_valid),
        .char_ascii  (char_ascii),
        .char_ack    (char_ack),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .length      (length),
        .buffer_full (buffer_full),
        .sending     (sending)
    );

    always #5 fpga_clock = ~fpga_clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: mbuf is the stored line, mtx the bytes still owed to the
    // transmitter; mphase 0=taking keys, 1=ack due, 2=waiting release, 3=sending.
    logic [7:0] mbuf[$];
    logic [7:0] mtx[$];
    logic [7:0] beats[$];
    int         mphase  = 0;
    bit         menter  = 1'b0;
    int         ack_cnt = 0;
    int         tv_cnt  = 0;

    function automatic int kind(input logic [7:0] c);
        if ((c >= 8'h20 && c <= 8'h7E) || (c >= 8'd128 && c <= 8'd131)) return 0;
        if (c == 8'h08) return 1;
        if (c == 8'h0A) return 2;
        return 3;
    endfunction

    always @(negedge fpga_clock) begin
        logic [7:0] exp_rd;
        check("char_ack", char_ack, mphase == 1);
        check("tx_valid", tx_valid, mphase == 3);
        check("sending", sending, mphase == 3);
        if (mphase == 3 && mtx.size() > 0) check("tx_data", tx_data, mtx[0]);
        check("length", length, mbuf.size());
        check("buffer_full", buffer_full, mbuf.size() == MAX_LEN);
        exp_rd = (int'(rd_addr) < mbuf.size()) ? mbuf[rd_addr] : 8'h00;
        check("rd_data", rd_data, exp_rd);
        if (char_ack) ack_cnt++;
        if (tx_valid) tv_cnt++;
        if (tx_valid && tx_ready) beats.push_back(tx_data);

        if (reset) begin
            mbuf.delete();
            mtx.delete();
            mphase = 0;
            menter = 1'b0;
        end else begin
            case (mphase)
                0: if (char_valid) begin
                    case (kind(char_ascii))
                        0: if (mbuf.size() < MAX_LEN) mbuf.push_back(char_ascii);
                        1: if (mbuf.size() > 0) void'(mbuf.pop_back());
                        2: if (mbuf.size() > 0) menter = 1'b1;
                        default: ;
                    endcase
                    mphase = 1;
                end
                1: mphase = 2;
                2: if (!char_valid) begin
                    if (menter) begin
                        mtx = mbuf;
                        mtx.push_back(8'h0A);
                        menter = 1'b0;
                        mphase = 3;
                    end else begin
                        mphase = 0;
                    end
                end
                3: if (tx_ready) begin
                    void'(mtx.pop_front());
                    if (mtx.size() == 0) begin
                        mbuf.delete();
                        mphase = 0;
                    end
                end
                default: mphase = 0;
            endcase
        end
    end

    // txmode: 0 = ready always high, 1 = random, 2 = fixed stall pattern
    int   txmode = 0;
    int   pidx   = 0;
    bit   randrd = 1'b0;
    logic pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    task automatic tick();
        @(posedge fpga_clock);
        #1;
        case (txmode)
            0: tx_ready = 1'b1;
            1: tx_ready = ($urandom_range(0, 9) < 7);
            default: begin
                if (sending) begin
                    tx_ready = (pidx < 7) ? pat[pidx] : 1'b1;
                    pidx++;
                end else begin
                    tx_ready = 1'b1;
                end
            end
        endcase
        if (randrd) rd_addr = ADDR_W'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((mphase != 0 || menter) && n < 500) begin
            tick();
            n++;
        end
        check("idle_timeout", n < 500, 1);
    endtask

    task automatic key(input logic [7:0] c, input int hold);
        char_ascii = c;
        char_valid = 1'b1;
        repeat (hold) tick();
        char_valid = 1'b0;
        wait_idle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic check_beats(input string name, input int b0,
                               input logic [7:0] e [4], input int n);
        check({name, "_count"}, beats.size() - b0, n);
        for (int i = 0; i < n && (b0 + i) < beats.size(); i++)
            check({name, "_byte"}, beats[b0 + i], e[i]);
    endtask

    initial begin
        int a0, b0, t0, n;
        logic [7:0] e [4];

        repeat (3) tick();
        reset = 1'b0;
        check("rst_length", length, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_char_ack", char_ack, 0);
        check("rst_sending", sending, 0);

        // "HI" + Enter with ready held high
        txmode = 0;
        a0 = ack_cnt;
        b0 = beats.size();
        key(8'h48, 5);
        key(8'h49, 5);
        key(8'h0A, 5);
        e = '{8'h48, 8'h49, 8'h0A, 8'h00};
        check_beats("hi_beats", b0, e, 3);
        check("hi_acks", ack_cnt - a0, 3);
        check("hi_length", length, 0);

        // Backspace editing and display read port
        key(8'h41, 2);
        key(8'h42, 1);
        key(8'h08, 3);
        key(8'h43, 2);
        check("edit_length", length, 2);
        rd_addr = 5'd0; #1; check("edit_rd0", rd_data, 8'h41);
        rd_addr = 5'd1; #1; check("edit_rd1", rd_data, 8'h43);
        rd_addr = 5'd2; #1; check("edit_rd2", rd_data, 8'h00);
        do_reset();

        // Backspace and Enter on empty line
        a0 = ack_cnt;
        t0 = tv_cnt;
        key(8'h08, 2);
        key(8'h0A, 2);
        check("empty_acks", ack_cnt - a0, 2);
        check("empty_length", length, 0);
        check("empty_no_tx", tv_cnt - t0, 0);

        // Overflow: 33 printable chars into 32 slots
        do_reset();
        a0 = ack_cnt;
        for (int i = 0; i < 33; i++) key(8'h21 + 8'(i), 1 + int'($urandom_range(0, 1)));
        check("full_length", length, 32);
        check("full_flag", buffer_full, 1);
        rd_addr = 5'd31; #1; check("full_rd31", rd_data, 8'h40);
        check("full_acks", ack_cnt - a0, 33);

        // Stalled send with a keystroke held during the send
        do_reset();
        key(8'h78, 1);
        key(8'h79, 1);
        key(8'h7A, 1);
        txmode = 2;
        pidx = 0;
        a0 = ack_cnt;
        b0 = beats.size();
        char_ascii = 8'h0A;
        char_valid = 1'b1;
        tick();
        char_valid = 1'b0;
        repeat (3) tick();
        char_ascii = 8'h51;
        char_valid = 1'b1;
        n = 0;
        while (ack_cnt - a0 < 2 && n < 100) begin
            tick();
            n++;
        end
        check("stall_ack_timeout", n < 100, 1);
        check("stall_beats_before_ack", beats.size() - b0, 4);
        char_valid = 1'b0;
        wait_idle();
        e = '{8'h78, 8'h79, 8'h7A, 8'h0A};
        check_beats("stall_beats", b0, e, 4);
        check("stall_acks", ack_cnt - a0, 2);
        check("stall_length", length, 1);
        rd_addr = 5'd0; #1; check("stall_rd0", rd_data, 8'h51);

        // Emoji message, then reset in the middle of a send
        do_reset();
        txmode = 0;
        b0 = beats.size();
        key(8'd130, 2);
        key(8'h0A, 2);
        e = '{8'h82, 8'h0A, 8'h00, 8'h00};
        check_beats("emoji_beats", b0, e, 2);
        key(8'h61, 1);
        key(8'h62, 1);
        b0 = beats.size();
        char_ascii = 8'h0A;
        char_valid = 1'b1;
        tick();
        char_valid = 1'b0;
        n = 0;
        while (beats.size() - b0 < 1 && n < 50) begin
            tick();
            n++;
        end
        check("midsend_timeout", n < 50, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midsend_tx_valid", tx_valid, 0);
        check("midsend_length", length, 0);
        check("midsend_sending", sending, 0);
        check("midsend_tx_data", tx_data, 0);
        tick();

        // Character present together with reset is discarded
        a0 = ack_cnt;
        char_ascii = 8'h4B;
        char_valid = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        char_valid = 1'b0;
        tick();
        tick();
        check("rstchar_length", length, 0);
        check("rstchar_acks", ack_cnt - a0, 0);

        // Randomized keystrokes against the model
        txmode = 1;
        randrd = 1'b1;
        for (int i = 0; i < 250; i++) begin
            int r;
            logic [7:0] c;
            r = int'($urandom_range(0, 99));
            if (r < 55)      c = 8'($urandom_range(8'h20, 8'h7E));
            else if (r < 65) c = 8'($urandom_range(128, 131));
            else if (r < 78) c = 8'h08;
            else if (r < 85) c = 8'h0A;
            else             c = 8'($urandom);
            if (r >= 97) do_reset();
            else key(c, int'($urandom_range(1, 5)));
        end
        txmode = 0;
        wait_idle();
        check("final_drain", mtx.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
